truth_table_sweeper: RTL

Sequencer that drives every input combination into one 3- or 4-input combinational function block and samples its output `Y`. It assembles the measured truth table, compares it against an expected table and reports the mismatches. It sits between the lab bench/top level and a single function instance such as the gate-level or operator-level implementations. It owns the `A`, `B`, `C`, `D` inputs of that instance for the whole sweep.

---
 rtl/lab_ctrl_pkg.sv | 19 +
 rtl/truth_table_sweeper.sv | 111 +++++++++++
 2 files changed

// File: rtl/lab_ctrl_pkg.sv
// Shared definitions for the lab control blocks.
//   sweep_state_t : sequencer states of truth_table_sweeper
//   IDX_W         : width of a truth-table index (up to 4 inputs)
//   TBL_W         : width of a full truth table (2^IDX_W entries)
//   ERR_W         : width of a mismatch count (0..TBL_W)
package lab_ctrl_pkg;

  localparam int IDX_W = 4;
  localparam int TBL_W = 16;
  localparam int ERR_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    FINISH  = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/truth_table_sweeper.sv
// Sweeps every input combination of a 3- or 4-input combinational block,
// records its Y output as a truth table and compares it with an expected
// table.
//
// Parameters:
//   SETTLE     : cycles each vector is held before Y is sampled (1..15)
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high; returns to IDLE, clears outputs
//   start      : request a sweep (honoured only in IDLE)
//   nvars      : 0 = 3-input function, 1 = 4-input function (latched at start)
//   expected   : expected truth table, bit i = Y for index i (latched at start)
//   f_in       : vector driven to the function under test ({A,B,C,D} or {0,A,B,C})
//   f_y        : Y returned by the function under test
//   busy       : sweep in progress
//   done       : one-cycle pulse at sweep end
//   table_out  : measured truth table
//   err_count  : number of mismatching indices
//   first_err  : lowest mismatching index, 0 if none
//   mismatch   : err_count != 0
module truth_table_sweeper
  import lab_ctrl_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             nvars,
  input  logic [TBL_W-1:0] expected,
  output logic [IDX_W-1:0] f_in,
  input  logic             f_y,
  output logic             busy,
  output logic             done,
  output logic [TBL_W-1:0] table_out,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_err,
  output logic             mismatch
);

  localparam logic [IDX_W-1:0] SETTLE_LAST = IDX_W'(SETTLE - 1);

  sweep_state_t     state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] settle_cnt;
  logic             nvars_q;
  logic [TBL_W-1:0] expected_q;
  logic [IDX_W-1:0] last_idx;
  logic             miss;

  assign last_idx = nvars_q ? IDX_W'(15) : IDX_W'(7);
  assign miss     = (f_y != expected_q[idx]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      nvars_q    <= 1'b0;
      expected_q <= '0;
      table_out  <= '0;
      err_count  <= '0;
      first_err  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            nvars_q    <= nvars;
            expected_q <= expected;
            table_out  <= '0;
            err_count  <= '0;
            first_err  <= '0;
            idx        <= '0;
            settle_cnt <= '0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (settle_cnt == SETTLE_LAST) state <= CAPTURE;
          else settle_cnt <= settle_cnt + IDX_W'(1);
        end
        CAPTURE: begin
          table_out[idx] <= f_y;
          if (miss) begin
            err_count <= err_count + ERR_W'(1);
            // err_count still holds the pre-increment value here, so zero
            // means this is the first mismatching index of the sweep.
            if (err_count == '0) first_err <= idx;
          end
          // Last-index test comes before the increment, so idx never wraps.
          if (idx == last_idx) begin
            state <= FINISH;
          end else begin
            idx        <= idx + IDX_W'(1);
            settle_cnt <= '0;
            state      <= WAIT;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // In 3-input mode idx stays below 8, so f_in[3] is naturally 0.
  assign busy     = (state == WAIT) || (state == CAPTURE);
  assign done     = (state == FINISH);
  assign f_in     = busy ? idx : '0;
  assign mismatch = (err_count != '0);

endmodule
